// File: rtl/hsync_pkg.sv
// hsync_pkg: shared state encoding and width helpers for the line packer
package hsync_pkg;
  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  function automatic int pw_w(input int ch, input int cw);
    return ch * cw;
  endfunction
  function automatic int lw_w(input int npix, input int ch, input int cw);
    return npix * ch * cw;
  endfunction
  function automatic int cnt_w(input int npix);
    return $clog2(npix + 1);
  endfunction
endpackage

// File: rtl/pixel_swizzle.sv
// pixel_swizzle: combinational channel reorder inside one pixel
module pixel_swizzle #(
  parameter int CH = 3,
  parameter int CW = 8,
  parameter bit REVERSE_CH = 1'b0
) (
  input  logic [CH*CW-1:0] pix_in,
  output logic [CH*CW-1:0] pix_out
);
  for (genvar c = 0; c < CH; c++) begin : g_ch
    localparam int SRC = REVERSE_CH ? CH - 1 - c : c;
    assign pix_out[c*CW +: CW] = pix_in[SRC*CW +: CW];
  end
endmodule

// File: rtl/hsync_line_packer.sv
// hsync_line_packer: packs hsync-gated pixels into line words behind a valid/ready register
module hsync_line_packer
  import hsync_pkg::*;
#(
  parameter int CH = 3,
  parameter int CW = 8,
  parameter int NPIX = 4,
  parameter bit REVERSE_CH = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          hsync,
  input  logic                          pix_valid,
  input  logic [pw_w(CH,CW)-1:0]        pix_data,
  output logic [lw_w(NPIX,CH,CW)-1:0]   line_data,
  output logic                          line_valid,
  input  logic                          line_ready,
  output logic                          line_short,
  output logic [cnt_w(NPIX)-1:0]        line_count,
  output logic                          overrun
);
  localparam int PW = pw_w(CH, CW);
  localparam int LW = lw_w(NPIX, CH, CW);
  localparam int CNTW = cnt_w(NPIX);
  state_t state;
  logic [CNTW-1:0] cnt;
  logic [LW-1:0] sr, shifted;
  logic [PW-1:0] sw;
  logic acc, full, short_done, comp;
  pixel_swizzle #(.CH(CH), .CW(CW), .REVERSE_CH(REVERSE_CH)) u_swz (
    .pix_in(pix_data),
    .pix_out(sw)
  );
  // accept and completion decode; a short word is simply the capture register as it stands
  always_comb begin
    acc = pix_valid & hsync & (state != DONE);
    shifted = {sr[LW-PW-1:0], sw};
    full = acc & (state == FILL) & (cnt == CNTW'(NPIX - 1));
    short_done = (state == FILL) & !hsync & (cnt != '0);
    comp = full | short_done;
  end
  // FSM, capture shift register and one-entry output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      sr <= '0;
      line_data <= '0;
      line_valid <= 1'b0;
      line_short <= 1'b0;
      line_count <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state == IDLE ? (hsync ? FILL : IDLE) :
               state == FILL ? (full ? DONE : (hsync ? FILL : IDLE)) :
               (hsync ? DONE : IDLE);
      if (comp) begin
        sr <= '0;
        cnt <= '0;
      end else if (acc) begin
        sr <= shifted;
        cnt <= cnt + CNTW'(1);
      end
      if (line_valid & line_ready) line_valid <= 1'b0;
      if (comp) begin
        if (!line_valid | line_ready) begin
          line_data <= full ? shifted : sr;
          line_short <= !full;
          line_count <= full ? CNTW'(NPIX) : cnt;
          line_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_hsync_line_packer.sv
// tb_hsync_line_packer: directed scoreboard bench for the line packer
module tb_hsync_line_packer;
  typedef struct packed {
    logic [95:0] d;
    logic        s;
    logic [2:0]  n;
  } exp_t;
  logic clk = 1'b0;
  logic rst, hsync, pix_valid, line_ready;
  logic [23:0] pix_data;
  logic [95:0] line_data, line_data_r;
  logic line_valid, line_short, overrun;
  logic line_valid_r, line_short_r, overrun_r;
  logic [2:0] line_count, line_count_r;
  exp_t q[$];
  int vectors = 0;
  int miscompares = 0;
  always #5 clk = ~clk;
  hsync_line_packer u0 (
    .clk(clk), .rst(rst), .hsync(hsync), .pix_valid(pix_valid), .pix_data(pix_data),
    .line_data(line_data), .line_valid(line_valid), .line_ready(line_ready),
    .line_short(line_short), .line_count(line_count), .overrun(overrun)
  );
  hsync_line_packer #(.REVERSE_CH(1'b1)) u1 (
    .clk(clk), .rst(rst), .hsync(hsync), .pix_valid(pix_valid), .pix_data(pix_data),
    .line_data(line_data_r), .line_valid(line_valid_r), .line_ready(line_ready),
    .line_short(line_short_r), .line_count(line_count_r), .overrun(overrun_r)
  );
  function automatic logic [95:0] rev(input logic [95:0] w);
    logic [95:0] r;
    r = '0;
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < 3; c++)
        r[s*24 + (2-c)*8 +: 8] = w[s*24 + c*8 +: 8];
    return r;
  endfunction
  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic px(input logic [23:0] d);
    hsync = 1'b1;
    pix_valid = 1'b1;
    pix_data = d;
    tick;
    pix_valid = 1'b0;
  endtask
  task automatic push(input logic [95:0] d, input logic s, input logic [2:0] n);
    exp_t e;
    e.d = d;
    e.s = s;
    e.n = n;
    q.push_back(e);
  endtask
  // scoreboard: every handshake must match the oldest expected word
  always @(negedge clk) begin
    if (!rst && line_valid && line_ready) begin
      exp_t e;
      chk("unexpected_word", 96'(q.size() != 0), 96'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("line_data", line_data, e.d);
        chk("line_short", 96'(line_short), 96'(e.s));
        chk("line_count", 96'(line_count), 96'(e.n));
        chk("rev_line_data", line_data_r, rev(e.d));
      end
    end
  end
  initial begin
    rst = 1'b1;
    hsync = 1'b0;
    pix_valid = 1'b0;
    pix_data = '0;
    line_ready = 1'b1;
    tick;
    tick;
    chk("rst_valid", 96'(line_valid), 96'd0);
    chk("rst_data", line_data, 96'd0);
    chk("rst_short", 96'(line_short), 96'd0);
    chk("rst_count", 96'(line_count), 96'd0);
    chk("rst_overrun", 96'(overrun), 96'd0);
    rst = 1'b0;
    tick;
    push(96'h010203_040506_070809_0A0B0C, 1'b0, 3'd4);
    px(24'h010203);
    px(24'h040506);
    px(24'h070809);
    chk("full_not_early", 96'(line_valid), 96'd0);
    px(24'h0A0B0C);
    chk("full_valid", 96'(line_valid), 96'd1);
    chk("full_count", 96'(line_count), 96'd4);
    px(24'hDEAD01);
    px(24'hDEAD02);
    hsync = 1'b0;
    tick;
    chk("full_consumed", 96'(line_valid), 96'd0);
    push(96'h000000_000000_AAAAAA_BBBBBB, 1'b1, 3'd2);
    px(24'hAAAAAA);
    px(24'hBBBBBB);
    hsync = 1'b0;
    tick;
    chk("short_valid", 96'(line_valid), 96'd1);
    chk("short_flag", 96'(line_short), 96'd1);
    tick;
    hsync = 1'b1;
    tick;
    tick;
    hsync = 1'b0;
    tick;
    pix_valid = 1'b1;
    pix_data = 24'h777777;
    tick;
    pix_valid = 1'b0;
    tick;
    chk("empty_line_no_word", 96'(line_valid), 96'd0);
    push({72'h0, 24'h112233}, 1'b1, 3'd1);
    px(24'h112233);
    hsync = 1'b0;
    tick;
    chk("rev_slot0", 96'(line_data_r[23:0]), 96'h332211);
    tick;
    line_ready = 1'b0;
    push(96'h100001_100002_100003_100004, 1'b0, 3'd4);
    px(24'h100001);
    px(24'h100002);
    px(24'h100003);
    px(24'h100004);
    hsync = 1'b0;
    tick;
    px(24'h200001);
    px(24'h200002);
    px(24'h200003);
    px(24'h200004);
    hsync = 1'b0;
    tick;
    chk("bp_overrun", 96'(overrun), 96'd1);
    chk("bp_valid", 96'(line_valid), 96'd1);
    chk("bp_hold", line_data, 96'h100001_100002_100003_100004);
    tick;
    tick;
    chk("bp_hold_later", line_data, 96'h100001_100002_100003_100004);
    chk("bp_overrun_sticky", 96'(overrun), 96'd1);
    line_ready = 1'b1;
    tick;
    tick;
    tick;
    chk("bp_drained", 96'(line_valid), 96'd0);
    chk("bp_overrun_kept", 96'(overrun), 96'd1);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    chk("rst_clears_overrun", 96'(overrun), 96'd0);
    line_ready = 1'b0;
    push(96'h300001_300002_300003_300004, 1'b0, 3'd4);
    px(24'h300001);
    px(24'h300002);
    px(24'h300003);
    px(24'h300004);
    hsync = 1'b0;
    tick;
    push(96'h400001_400002_400003_400004, 1'b0, 3'd4);
    px(24'h400001);
    px(24'h400002);
    px(24'h400003);
    line_ready = 1'b1;
    px(24'h400004);
    chk("sim_valid", 96'(line_valid), 96'd1);
    chk("sim_data", line_data, 96'h400001_400002_400003_400004);
    chk("sim_overrun", 96'(overrun), 96'd0);
    hsync = 1'b0;
    tick;
    tick;
    px(24'h500001);
    px(24'h500002);
    px(24'h500003);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    hsync = 1'b0;
    tick;
    chk("rst_mid_no_word", 96'(line_valid), 96'd0);
    push(96'h600001_600002_600003_600004, 1'b0, 3'd4);
    px(24'h600001);
    px(24'h600002);
    px(24'h600003);
    px(24'h600004);
    px(24'h6000EE);
    px(24'h6000FF);
    hsync = 1'b0;
    tick;
    tick;
    tick;
    chk("scoreboard_drained", 96'(q.size()), 96'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/hsync_line_packer.md
# hsync_line_packer

Parametrised successor to the single-pixel horizontal sync stage. It captures pixel beats of CH channels × CW bits while hsync is high and packs NPIX pixels into one line word, with optional channel-order swap. Completed words, full or short, are handed downstream through a one-entry valid/ready output register. It sits between the pixel source (camera/VGA timing path) and the frame/line consumer.

## Interface
- CH, 3, channels per pixel
- CW, 8, bits per channel
- NPIX, 4, pixels per line word (≥2)
- REVERSE_CH, 0, 1 = reverse channel order inside each pixel slot
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous reset, active-high
- hsync  in  1  line active (high during active pixels)
- pix_valid  in  1  pix_data valid this cycle
- pix_data  in  CH*CW  pixel; channel c at [c*CW +: CW]
- line_data  out  NPIX*CH*CW  packed line word
- line_valid  out  1  line_data holds an unconsumed word
- line_ready  in  1  downstream accepts when line_valid & line_ready
- line_short  out  1  word ended by hsync fall before NPIX pixels
- line_count  out  $clog2(NPIX+1)  pixels in word (1..NPIX)
- overrun  out  1  sticky: a completed word was dropped

## Operation
- Accept = pix_valid & hsync & state ∈ {IDLE, FILL}; pixels with hsync low are ignored.
- Pack: accepted pixel (after swizzle) shifts in at the LSB slot; older pixels move up one slot of PW=CH*CW bits. Full word: first pixel in MSB slot, last in [PW-1:0].
- Swizzle: REVERSE_CH=1 moves channel c to slot CH-1-c; REVERSE_CH=0 passes through.
- FSM:
  - IDLE: hsync=1 → FILL; an accept in the same cycle counts as pixel 0.
  - FILL: on the NPIX-th accept, complete a full word → DONE. If hsync=0 with count>0, complete a short word → IDLE. If hsync=0 with count=0 → IDLE.
  - DONE: ignore pixels; hsync=0 → IDLE.
- Completion: the capture shift register and count clear in the same cycle. A short word keeps its pixels in the low slots, upper slots zero, line_short=1, line_count=n.
- Output register: loads on completion if line_valid=0 or (line_valid & line_ready) that cycle. Otherwise the word is dropped and overrun is set; it clears only on rst.

## Timing
- Reset: line_data=0, line_valid=0, line_short=0, line_count=0, overrun=0, state IDLE, count 0, capture register 0.
- Latency: line_valid rises on the clock after the completing accept (full) or after the hsync-low cycle (short); line_data, line_short and line_count update on the same edge.
- Handshake: line_data, line_short and line_count are stable while line_valid & !line_ready. line_valid drops the cycle after a handshake unless a new completion loads on that same edge, in which case it stays 1 with the new word.
- Back-to-back lines: a 1-cycle hsync low between lines is sufficient; throughput is 1 pixel/cycle.
- rst mid-line: partial word discarded, no output, state IDLE.
- hsync falling with count=NPIX cannot occur in FILL: the word has already completed and the FSM is in DONE.

## Structure
- Shared package hsync_pkg:
  - state enum {IDLE, FILL, DONE}
  - functions for PW=CH*CW, LW=NPIX*PW and CNTW=$clog2(NPIX+1)
- One sub-module, pixel_swizzle: combinational channel reorder, parameters CH, CW, REVERSE_CH.
- Remaining logic (FSM, counter, shift register, output register) lives in the top module.

## Test plan
- Full line, defaults: hsync=1, pixels 0x010203, 0x040506, 0x070809, 0x0A0B0C; line_ready=1 → one cycle later line_data=0x010203_040506_070809_0A0B0C, line_count=4, line_short=0.
- REVERSE_CH=1: single pixel 0x112233 in a 4-pixel line → slot 0 of line_data = 0x332211.
- Short line: 2 pixels (0xAAAAAA, 0xBBBBBB) then hsync=0 → line_data=0x000000_000000_AAAAAA_BBBBBB, line_short=1, line_count=2. A line with 0 pixels produces no output.
- Backpressure/overrun: line_ready=0; complete two full lines → first word held stable, second dropped, overrun=1 and stays 1. Raise line_ready → exactly one handshake.
- Simultaneous: line_ready=1 on the same edge a new word completes → line_valid stays 1, new word loaded, overrun=0.
- Reset mid-line: rst after 3 accepts, then a fresh 4-pixel line → only the fresh word emitted, count=4. Extra pixels beyond 4 while hsync stays high are ignored.
